// File: rtl/ascon_perm_unrolled.sv
// Ascon-p permutation engine: UNROLL rounds per clock and 1..12 rounds per request.
// Uses a valid/ready handshake on both sides, with pass-through from HOLD to RUN for back-to-back work.
module ascon_perm_unrolled #(
   parameter int UNROLL    = 2,
   parameter bit RESET_OUT = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [3:0]   nrounds,
   input  logic [319:0] state_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [319:0] state_out,
   output logic         busy,
   output logic         err
);

   typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

   state_t       state;
   logic [3:0]   r;
   logic [3:0]   r_next;
   logic [319:0] x;
   logic [319:0] x_next;
   logic         accept;
   logic         legal;
   logic         finish;

   function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
      return (v >> n) | (v << (64 - n));
   endfunction

   // One Ascon round: round constant into x2, bitsliced S-box, then linear diffusion.
   function automatic logic [319:0] round_fn(input logic [319:0] s, input logic [3:0] ri);
      logic [63:0] a0, a1, a2, a3, a4;
      logic [63:0] t0, t1, t2, t3, t4;
      a0 = s[319:256];
      a1 = s[255:192];
      a2 = s[191:128] ^ {56'd0, 4'hF - ri, ri};
      a3 = s[127:64];
      a4 = s[63:0];
      a0 = a0 ^ a4;
      a4 = a4 ^ a3;
      a2 = a2 ^ a1;
      t0 = a0 ^ (~a1 & a2);
      t1 = a1 ^ (~a2 & a3);
      t2 = a2 ^ (~a3 & a4);
      t3 = a3 ^ (~a4 & a0);
      t4 = a4 ^ (~a0 & a1);
      t1 = t1 ^ t0;
      t0 = t0 ^ t4;
      t3 = t3 ^ t2;
      t2 = ~t2;
      a0 = t0 ^ rotr(t0, 19) ^ rotr(t0, 28);
      a1 = t1 ^ rotr(t1, 61) ^ rotr(t1, 39);
      a2 = t2 ^ rotr(t2, 1)  ^ rotr(t2, 6);
      a3 = t3 ^ rotr(t3, 10) ^ rotr(t3, 17);
      a4 = t4 ^ rotr(t4, 7)  ^ rotr(t4, 41);
      return {a0, a1, a2, a3, a4};
   endfunction

   always_comb begin
      x_next = x;
      for (int k = 0; k < UNROLL; k++) begin
         x_next = round_fn(x_next, r + 4'(k));
      end
   end

   assign r_next   = r + 4'(UNROLL);
   assign legal    = (nrounds != 4'd0) && (nrounds <= 4'd12) && ((nrounds % 4'(UNROLL)) == 4'd0);
   assign in_ready = (state == IDLE) || ((state == HOLD) && out_ready);
   assign accept   = in_valid && in_ready;
   assign finish   = (state == RUN) && (r_next == 4'd12);

   // An illegal request still completes its handshake, but it only raises err and leaves the engine idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         r         <= 4'd0;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         err       <= 1'b0;
      end else begin
         err <= 1'b0;
         unique case (state)
            RUN: begin
               r <= r_next;
               if (r_next == 4'd12) begin
                  state     <= HOLD;
                  busy      <= 1'b0;
                  out_valid <= 1'b1;
               end
            end
            default: begin
               if (accept && legal) begin
                  r         <= 4'd12 - nrounds;
                  state     <= RUN;
                  busy      <= 1'b1;
                  out_valid <= 1'b0;
               end else if (accept) begin
                  err       <= 1'b1;
                  state     <= IDLE;
                  out_valid <= 1'b0;
               end else if ((state == HOLD) && out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (state == RUN) begin
         x <= x_next;
      end else if (accept && legal) begin
         x <= state_in;
      end
   end

   // The result register stays frozen through HOLD. A reset discards any result that is still in flight.
   always_ff @(posedge clk) begin
      if (rst && RESET_OUT) begin
         state_out <= '0;
      end else if (!rst && finish) begin
         state_out <= x_next;
      end
   end

endmodule

// File: tb/tb_ascon_perm_unrolled.sv
// Bench for ascon_perm_unrolled: six engines (UNROLL 2,1,3,4,6,12), each checked every cycle against
// a column-lookup Ascon-p model with a request/latency scoreboard.
module tb_ascon_perm_unrolled;

   localparam int NL = 6;

   function automatic int unroll_of(input int g);
      case (g)
         0:       return 2;
         1:       return 1;
         2:       return 3;
         3:       return 4;
         4:       return 6;
         default: return 12;
      endcase
   endfunction

   localparam logic [4:0] SBOX [32] = '{
      5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
      5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
      5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
      5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

   localparam logic [319:0] HASH_IV  = {64'h00400c0000000100, 256'd0};
   localparam logic [319:0] HASH_P12 = {64'hee9398aadb67f03d, 64'h8bb21831c60f1002,
                                        64'hb48a92db98d5da62, 64'h43189921b8f8e3e8,
                                        64'h348fa5c9d525e140};

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic         in_valid  [NL];
   logic         in_ready  [NL];
   logic [3:0]   nrounds   [NL];
   logic [319:0] state_in  [NL];
   logic         out_valid [NL];
   logic         out_ready [NL];
   logic [319:0] state_out [NL];
   logic         busy      [NL];
   logic         err       [NL];

   int checks = 0;
   int errors = 0;

   // ---------------- reference model ----------------
   function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
      return (v >> n) | (v << (64 - n));
   endfunction

   function automatic logic [7:0] rc(input int ri);
      return 8'(((15 - ri) << 4) | ri);
   endfunction

   // Substitution layer evaluated column by column through the 5-bit S-box table
   function automatic logic [319:0] sub_layer(input logic [319:0] s);
      logic [63:0] w [5];
      logic [63:0] o [5];
      logic [4:0]  col;
      logic [4:0]  y;
      for (int i = 0; i < 5; i++) begin
         w[i] = s[319 - 64 * i -: 64];
         o[i] = '0;
      end
      for (int b = 0; b < 64; b++) begin
         col = {w[0][b], w[1][b], w[2][b], w[3][b], w[4][b]};
         y   = SBOX[col];
         for (int i = 0; i < 5; i++) o[i][b] = y[4 - i];
      end
      return {o[0], o[1], o[2], o[3], o[4]};
   endfunction

   function automatic logic [319:0] ref_round(input logic [319:0] s, input int ri);
      logic [319:0] t;
      logic [63:0]  w0, w1, w2, w3, w4;
      t  = sub_layer(s ^ {128'd0, 56'd0, rc(ri), 128'd0});
      w0 = t[319:256];
      w1 = t[255:192];
      w2 = t[191:128];
      w3 = t[127:64];
      w4 = t[63:0];
      return {w0 ^ rotr(w0, 19) ^ rotr(w0, 28), w1 ^ rotr(w1, 61) ^ rotr(w1, 39),
              w2 ^ rotr(w2, 1) ^ rotr(w2, 6),   w3 ^ rotr(w3, 10) ^ rotr(w3, 17),
              w4 ^ rotr(w4, 7) ^ rotr(w4, 41)};
   endfunction

   function automatic logic [319:0] ref_perm(input logic [319:0] s, input int n);
      logic [319:0] v;
      v = s;
      for (int i = 12 - n; i < 12; i++) v = ref_round(v, i);
      return v;
   endfunction

   function automatic logic [319:0] rand320();
      logic [319:0] v;
      for (int i = 0; i < 10; i++) v[32 * i +: 32] = $urandom;
      return v;
   endfunction

   task automatic checkOutput(input string name, input int lane, input logic [319:0] act,
                              input logic [319:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s lane %0d: got %h expected %h", name, lane, act, exp);
      end
   endtask

   // ---------------- DUTs, per-lane scoreboard and compare ----------------
   for (genvar g = 0; g < NL; g++) begin : lane
      localparam int U  = unroll_of(g);
      localparam bit RO = (g != NL - 1);

      ascon_perm_unrolled #(.UNROLL(U), .RESET_OUT(RO)) dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready[g]),
         .nrounds   (nrounds[g]),
         .state_in  (state_in[g]),
         .out_valid (out_valid[g]),
         .out_ready (out_ready[g]),
         .state_out (state_out[g]),
         .busy      (busy[g]),
         .err       (err[g])
      );

      int           m_cnt   = 0;
      bit           m_hold  = 1'b0;
      bit           m_err   = 1'b0;
      bit           m_fresh = 1'b0;
      bit           m_live  = 1'b0;
      logic [319:0] m_res   = '0;
      logic [319:0] m_out   = '0;

      // m_cnt counts the remaining busy cycles of the accepted request; m_hold means a result is waiting.
      always @(posedge clk) begin
         bit rdy;
         bit acc;
         int n;
         if (rst) begin
            m_cnt   = 0;
            m_hold  = 1'b0;
            m_err   = 1'b0;
            m_fresh = 1'b1;
            m_live  = 1'b1;
            m_out   = '0;
         end else begin
            m_fresh = 1'b0;
            m_err   = 1'b0;
            n       = int'(nrounds[g]);
            rdy     = (m_cnt == 0) && (!m_hold || out_ready[g]);
            acc     = in_valid[g] && rdy;
            if (m_cnt > 0) begin
               m_cnt--;
               if (m_cnt == 0) begin
                  m_hold = 1'b1;
                  m_out  = m_res;
               end
            end else if (m_hold && out_ready[g]) begin
               m_hold = 1'b0;
            end
            if (acc) begin
               if (n >= 1 && n <= 12 && (n % U) == 0) begin
                  m_res = ref_perm(state_in[g], n);
                  m_cnt = n / U;
               end else begin
                  m_err = 1'b1;
               end
            end
         end
      end

      always @(negedge clk) begin
         if (m_live) begin
            checkOutput("in_ready", g, in_ready[g], (m_cnt == 0) && (!m_hold || out_ready[g]));
            checkOutput("out_valid", g, out_valid[g], m_hold);
            checkOutput("busy", g, busy[g], m_cnt > 0);
            checkOutput("err", g, err[g], m_err);
            if (m_hold || (m_fresh && RO)) checkOutput("state_out", g, state_out[g], m_out);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic stepCycle();
      @(posedge clk);
      #3;
   endtask

   task automatic applyStimulus(input int g, input logic [319:0] s, input logic [3:0] n, input bit bp);
      bit done = 1'b0;
      state_in[g] = s;
      nrounds[g]  = n;
      in_valid[g] = 1'b1;
      for (int i = 0; i < 200 && !done; i++) begin
         if (bp) out_ready[g] = ($urandom_range(0, 3) != 0);
         #1;
         done = in_ready[g];
         stepCycle();
      end
      in_valid[g] = 1'b0;
      state_in[g] = rand320();
      nrounds[g]  = 4'($urandom_range(0, 15));
      checks++;
      if (!done) begin
         errors++;
         $display("[TB] FAIL accept_timeout lane %0d: got no accept expected accept", g);
      end
   endtask

   task automatic waitResult(input int g, output int lat);
      lat = 0;
      while (!out_valid[g] && lat < 200) begin
         stepCycle();
         lat++;
      end
      checks++;
      if (!out_valid[g]) begin
         errors++;
         $display("[TB] FAIL result_timeout lane %0d: got no out_valid expected out_valid", g);
      end
   endtask

   initial begin
      #900000;
      $display("[TB] FAIL watchdog: got no finish expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int lat;
      int u;
      for (int g = 0; g < NL; g++) begin
         in_valid[g]  = 1'b0;
         out_ready[g] = 1'b1;
         nrounds[g]   = 4'd0;
         state_in[g]  = '0;
      end
      rst = 1'b1;

      checkOutput("rc0", -1, rc(0), 8'hF0);
      checkOutput("rc4", -1, rc(4), 8'hB4);
      checkOutput("rc6", -1, rc(6), 8'h96);
      checkOutput("rc11", -1, rc(11), 8'h4B);
      checkOutput("sbox_layer", -1, sub_layer({128'd0, 64'hF0, 128'd0}),
                  {64'hF0, 64'hF0, 64'hFFFFFFFFFFFFFF0F, 64'hF0, 64'h0});
      checkOutput("model_hash_iv", -1, ref_perm(HASH_IV, 12), HASH_P12);

      repeat (2) stepCycle();
      rst = 1'b0;
      stepCycle();

      $display("[TB] p12 on zero state and on the hash IV");
      applyStimulus(0, '0, 4'd12, 1'b0);
      waitResult(0, lat);
      checkOutput("latency_p12", 0, lat, 6);
      stepCycle();
      applyStimulus(0, HASH_IV, 4'd12, 1'b0);
      waitResult(0, lat);
      checkOutput("hash_iv_p12", 0, state_out[0], HASH_P12);
      stepCycle();

      $display("[TB] p6 and p8 on random states");
      applyStimulus(0, rand320(), 4'd6, 1'b0);
      waitResult(0, lat);
      checkOutput("latency_p6", 0, lat, 3);
      applyStimulus(0, rand320(), 4'd8, 1'b0);
      waitResult(0, lat);
      checkOutput("latency_p8", 0, lat, 4);
      stepCycle();

      $display("[TB] illegal round counts");
      applyStimulus(0, rand320(), 4'd5, 1'b0);
      repeat (2) stepCycle();
      applyStimulus(0, rand320(), 4'd0, 1'b0);
      applyStimulus(0, rand320(), 4'd13, 1'b0);
      applyStimulus(0, rand320(), 4'd12, 1'b0);
      waitResult(0, lat);
      checkOutput("latency_after_err", 0, lat, 6);
      stepCycle();

      $display("[TB] backpressure in HOLD then pass-through accept");
      out_ready[0] = 1'b0;
      applyStimulus(0, rand320(), 4'd12, 1'b0);
      waitResult(0, lat);
      repeat (5) stepCycle();
      out_ready[0] = 1'b1;
      applyStimulus(0, rand320(), 4'd12, 1'b0);
      waitResult(0, lat);
      checkOutput("latency_passthrough", 0, lat, 6);
      stepCycle();

      $display("[TB] reset during a p12 run");
      applyStimulus(0, rand320(), 4'd12, 1'b0);
      repeat (2) stepCycle();
      rst = 1'b1;
      stepCycle();
      rst = 1'b0;
      repeat (2) stepCycle();
      applyStimulus(0, rand320(), 4'd12, 1'b0);
      waitResult(0, lat);
      checkOutput("latency_after_reset", 0, lat, 6);

      $display("[TB] random requests with random backpressure");
      for (int k = 0; k < 30; k++) applyStimulus(0, rand320(), 4'($urandom_range(0, 15)), 1'b1);
      out_ready[0] = 1'b1;
      repeat (15) stepCycle();

      $display("[TB] UNROLL sweep");
      for (int g = 1; g < NL; g++) begin
         u = unroll_of(g);
         for (int k = 0; k < 100; k++) applyStimulus(g, rand320(), 4'd12, 1'($urandom_range(0, 1)));
         out_ready[g] = 1'b1;
         for (int n = u; n <= 12; n += u) begin
            applyStimulus(g, rand320(), 4'(n), 1'b0);
            waitResult(g, lat);
            checkOutput("latency_sweep", g, lat, n / u);
         end
         applyStimulus(g, rand320(), 4'd0, 1'b0);
         repeat (15) stepCycle();
      end

      repeat (5) stepCycle();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
